fifo_reader: RTL and testbench

Read-side adapter for the synchronous `fifo` block. It drives the FIFO's take strobe from the FIFO's empty flag and registered read data. It re-presents the words on a valid/ready stream for downstream consumers. A 2-entry skid buffer hides the FIFO's 1-cycle read latency, so a continuously ready consumer sees 1 word/cycle.

---
 rtl/fifo_reader_pkg.sv | 32 +++
 rtl/fifo_reader_skid.sv | 121 ++++++++++++
 rtl/fifo_reader.sv | 115 +++++++++++
 tb/tb_fifo_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_reader_pkg
//
// Shared types and constants for the fifo_reader read-side adapter.
//
// Contents:
//   occ_e       - occupancy of the 2-entry skid buffer (0, 1 or 2 words)
//   SKID_DEPTH  - number of words the skid buffer can hold
//   occ_words() - numeric word count for an occupancy value
//
// The optional transfer counter in fifo_reader is enabled by defining the
// macro FIFO_READER_COUNT_EN. This package does not depend on it.
// -----------------------------------------------------------------------------
package fifo_reader_pkg;

    // Buffered-word count. The numeric encoding equals the word count, so
    // occ_words() is a plain cast.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Two entries cover the single cycle of FIFO read latency: one word
    // being presented downstream plus one word arriving from the FIFO.
    localparam int SKID_DEPTH = 2;

    function automatic logic [1:0] occ_words(input occ_e occ);
        return 2'(occ);
    endfunction

endpackage : fifo_reader_pkg

// File: rtl/fifo_reader_skid.sv
// -----------------------------------------------------------------------------
// fifo_reader_skid
//
// Two-entry head/tail skid buffer. The head is the word presented
// downstream; the tail holds a second word captured while the head is
// stalled. On a pop with two words buffered, the tail moves into the head.
//
// Ports:
//   in_clock    input   clock, rising edge
//   in_reset    input   synchronous, active-high reset
//   in_capture  input   in_data is written into the buffer at this edge
//   in_pop      input   the head word is consumed at this edge
//   in_data     input   word to capture
//   out_occ     output  current occupancy (registered)
//   out_head    output  head word (registered)
//
// The caller guarantees that capture never arrives while the buffer is
// full without a simultaneous pop, and that pop never arrives while the
// buffer is empty.
// -----------------------------------------------------------------------------
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic                  in_capture,
    input  logic                  in_pop,
    input  logic [DATA_WIDTH-1:0] in_data,
    output occ_e                  out_occ,
    output logic [DATA_WIDTH-1:0] out_head
);

    occ_e                  r_occ;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    occ_e                  w_occ_next;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic [DATA_WIDTH-1:0] w_tail_next;

    // State register.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            // NOTE: the data entries are reset as well, not just the
            // occupancy: out_data is visible downstream and must read 0
            // after reset. With two entries this costs almost nothing.
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_occ  <= w_occ_next;
            r_head <= w_head_next;
            r_tail <= w_tail_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: hold-by-default on every variable first; any path that does
        // not assign them would otherwise infer a latch.
        w_occ_next  = r_occ;
        w_head_next = r_head;
        w_tail_next = r_tail;

        case ({in_capture, in_pop})
            2'b10: begin
                // Capture only: fill the first free slot.
                case (r_occ)
                    OCC_EMPTY: begin
                        w_head_next = in_data;
                        w_occ_next  = OCC_ONE;
                    end
                    OCC_ONE: begin
                        w_tail_next = in_data;
                        w_occ_next  = OCC_TWO;
                    end
                    default: ; // full: excluded by the take rule
                endcase
            end
            2'b01: begin
                // Pop only: advance the tail, or drain the last word.
                case (r_occ)
                    OCC_TWO: begin
                        w_head_next = r_tail;
                        w_occ_next  = OCC_ONE;
                    end
                    OCC_ONE: begin
                        w_occ_next  = OCC_EMPTY;
                    end
                    default: ; // empty: pop cannot occur without out_valid
                endcase
            end
            2'b11: begin
                // Capture and pop together: occupancy is unchanged. The new
                // word lands in the head if the pop leaves the buffer empty.
                case (r_occ)
                    OCC_TWO: begin
                        w_head_next = r_tail;
                        w_tail_next = in_data;
                    end
                    default: begin
                        w_head_next = in_data;
                        w_occ_next  = OCC_ONE;
                    end
                endcase
            end
            default: ; // neither: hold
        endcase
    end

    // Outputs come straight from the registers.
    always_comb begin
        out_occ  = r_occ;
        out_head = r_head;
    end

endmodule : fifo_reader_skid

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Read-side adapter for the synchronous fifo block. It issues take strobes
// to the FIFO and re-presents the returned words on a valid/ready stream.
// The FIFO has one cycle of read latency, so a two-entry skid buffer
// absorbs the word that is still in flight when downstream stalls. A
// continuously ready consumer therefore sees one word per cycle.
//
// Parameters:
//   DATA_WIDTH   word width; must match the attached FIFO
//   COUNT_WIDTH  transfer counter width (only with FIFO_READER_COUNT_EN)
//
// Ports:
//   in_clock       input   clock, rising edge
//   in_reset       input   synchronous, active-high reset (shared with FIFO)
//   in_fifo_empty  input   FIFO empty flag
//   in_fifo_data   input   FIFO read data, valid the cycle after a take
//   out_fifo_take  output  take strobe to FIFO (combinational)
//   out_valid      output  a word is available downstream
//   out_data       output  downstream word, stable while stalled
//   in_ready       input   downstream accepts out_data this cycle
//   out_count      output  accepted-transfer count, wraps
//                          (only with FIFO_READER_COUNT_EN)
//
// Build option:
//   FIFO_READER_COUNT_EN  when defined, adds COUNT_WIDTH and out_count.
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 8
`ifdef FIFO_READER_COUNT_EN
    ,
    parameter int COUNT_WIDTH = 16
`endif
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic                   in_fifo_empty,
    input  logic [DATA_WIDTH-1:0]  in_fifo_data,
    output logic                   out_fifo_take,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   in_ready
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] out_count
`endif
);

    // Set when a take was issued last cycle, so in_fifo_data holds a word
    // that must be captured at the coming edge.
    logic                  r_inflight;

    occ_e                  w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_take;

    // Downstream transfer this cycle.
    assign w_pop = out_valid & in_ready;

    // Words already owned by the adapter: buffered plus in flight.
    assign w_level = {1'b0, occ_words(w_occ)} + {2'b00, r_inflight};

    // Take only if, after this cycle's pop, there is still room for the
    // word the take will return. Written as level < depth + pop so the
    // arithmetic never underflows. Because pop is combinational here, a
    // stalled stream resumes taking in the same cycle in_ready rises.
    assign w_take = !in_reset && !in_fifo_empty
                 && (w_level < (3'(SKID_DEPTH) + {2'b00, w_pop}));

    assign out_fifo_take = w_take;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_take;
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .in_clock   (in_clock),
        .in_reset   (in_reset),
        .in_capture (r_inflight),
        .in_pop     (w_pop),
        .in_data    (in_fifo_data),
        .out_occ    (w_occ),
        .out_head   (w_head)
    );

    assign out_valid = (w_occ != OCC_EMPTY);
    assign out_data  = w_head;

`ifdef FIFO_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_count;

    // Counts accepted transfers; wraps naturally at 2^COUNT_WIDTH.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_count = r_count;
`endif

endmodule : fifo_reader

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
//
// Bench for fifo_reader. A behavioural FIFO (a queue) answers take strobes
// with one cycle of latency. A scoreboard queue holds every word written to
// the FIFO, in order; each downstream transfer must match its head. The
// adapter's word holding (takes minus transfers) must never exceed two.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          in_clock      = 1'b0;
    logic          in_reset      = 1'b1;
    logic          in_fifo_empty = 1'b1;
    logic [DW-1:0] in_fifo_data  = '0;
    logic          in_ready      = 1'b0;
    logic          out_fifo_take;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef FIFO_READER_COUNT_EN
    logic [CW-1:0] out_count;
`endif

    fifo_reader #(
        .DATA_WIDTH    (DW)
`ifdef FIFO_READER_COUNT_EN
        ,
        .COUNT_WIDTH   (CW)
`endif
    ) dut (
        .in_clock      (in_clock),
        .in_reset      (in_reset),
        .in_fifo_empty (in_fifo_empty),
        .in_fifo_data  (in_fifo_data),
        .out_fifo_take (out_fifo_take),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .in_ready      (in_ready)
`ifdef FIFO_READER_COUNT_EN
        ,
        .out_count     (out_count)
`endif
    );

    always #5 in_clock = ~in_clock;

    // ---------------------------------------------------------------------
    // Check bookkeeping
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // FIFO model, scoreboard and monitor
    // ---------------------------------------------------------------------
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            held      = 0;
    logic [CW-1:0] pop_total = '0;
    logic          take_s    = 1'b0;
    logic          pop_s     = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    // Stimulus requests, applied by the FIFO model at the next rising edge.
    logic          put_req   = 1'b0;
    logic [DW-1:0] put_word  = '0;
    int            load_n    = 0;
    logic [DW-1:0] load_base = '0;

    always @(in_clock) begin
        if (in_clock) begin
            // Rising edge: FIFO pops on take, accepts writes; the adapter's
            // holding changes by takes minus transfers.
            if (in_reset) begin
                fifo_q.delete();
                exp_q.delete();
                held      = 0;
                pop_total = '0;
            end else begin
                if (take_s && fifo_q.size() != 0) in_fifo_data <= fifo_q.pop_front();
                held = held + int'(take_s) - int'(pop_s);
                if (pop_s) pop_total = pop_total + 1'b1;
                if (put_req) begin
                    fifo_q.push_back(put_word);
                    exp_q.push_back(put_word);
                end
            end
            for (int k = 0; k < load_n; k++) begin
                fifo_q.push_back(load_base + DW'(k));
                exp_q.push_back(load_base + DW'(k));
            end
            in_fifo_empty <= (fifo_q.size() == 0);
        end else begin
            // Falling edge: sample and check outputs.
            if (in_reset) begin
                take_s     = 1'b0;
                pop_s      = 1'b0;
                prev_stall = 1'b0;
            end else begin
                take_s = out_fifo_take;
                pop_s  = out_valid & in_ready;
                if (take_s) check("take_when_empty", 32'(in_fifo_empty), 32'd0);
                check("occ_bound", 32'(held <= 2), 32'd1);
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (pop_s) begin
                    if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 32'd1);
                    else                   check("order", 32'(out_data), 32'(exp_q.pop_front()));
                end
`ifdef FIFO_READER_COUNT_EN
                check("count", 32'(out_count), 32'(pop_total));
`endif
                prev_stall = out_valid & !in_ready;
                prev_data  = out_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Table-driven vectors
    // ---------------------------------------------------------------------
    typedef struct {
        logic          ready;
        logic          put;
        logic [DW-1:0] put_data;
        logic          exp_take;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vec[0:31];

    task automatic set_vec(input int i, input logic rdy, input logic take, input logic vld,
                           input logic [DW-1:0] data);
        vec[i].ready     = rdy;
        vec[i].put       = 1'b0;
        vec[i].put_data  = '0;
        vec[i].exp_take  = take;
        vec[i].exp_valid = vld;
        vec[i].exp_data  = data;
    endtask

    // Optional load of words base..base+load-1 one edge before cycle 0.
    task automatic run_table(input string tag, input int n, input int load);
        if (load > 0) begin
            @(posedge in_clock); #1;
            load_n    = load;
            load_base = '0;
            in_ready  = vec[0].ready;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge in_clock); #1;
            load_n   = 0;
            in_ready = vec[i].ready;
            put_req  = vec[i].put;
            put_word = vec[i].put_data;
            @(negedge in_clock);
            check($sformatf("%s[%0d].take", tag, i), 32'(out_fifo_take), 32'(vec[i].exp_take));
            check($sformatf("%s[%0d].valid", tag, i), 32'(out_valid), 32'(vec[i].exp_valid));
            if (vec[i].exp_valid)
                check($sformatf("%s[%0d].data", tag, i), 32'(out_data), 32'(vec[i].exp_data));
        end
        @(posedge in_clock); #1;
        put_req = 1'b0;
    endtask

    // Ready high, no new writes, until everything written has been delivered.
    task automatic drain(input string tag);
        int cyc;
        in_ready = 1'b1;
        put_req  = 1'b0;
        cyc      = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 600) begin
            @(posedge in_clock); #1;
            cyc++;
        end
        @(negedge in_clock);
        check({tag, ".drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, ".valid_low"}, 32'(out_valid), 32'd0);
    endtask

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        // Reset with the FIFO holding three words.
        in_reset = 1'b1;
        in_ready = 1'b1;
        @(posedge in_clock); #1;
        load_n    = 3;
        load_base = 8'h11;
        @(posedge in_clock); #1;
        load_n = 0;
        @(negedge in_clock);
        check("rst.fifo_not_empty", 32'(in_fifo_empty), 32'd0);
        check("rst.take", 32'(out_fifo_take), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        in_ready = 1'b0;
        @(negedge in_clock);
        check("post_rst.valid", 32'(out_valid), 32'd0);
        check("post_rst.data", 32'(out_data), 32'd0);
        check("post_rst.take", 32'(out_fifo_take), 32'd0);
`ifdef FIFO_READER_COUNT_EN
        check("post_rst.count", 32'(out_count), 32'd0);
`endif

        // Single word 0xAA: take the cycle after the write, shown two
        // cycles after the take edge, for one cycle.
        for (int i = 0; i < 5; i++) set_vec(i, 1'b1, 1'b0, 1'b0, '0);
        vec[0].put      = 1'b1;
        vec[0].put_data = 8'hAA;
        vec[1].exp_take = 1'b1;
        vec[3].exp_valid = 1'b1;
        vec[3].exp_data  = 8'hAA;
        run_table("single", 5, 0);
`ifdef FIFO_READER_COUNT_EN
        check("single.count", 32'(out_count), 32'd1);
`endif

        // Sixteen words, always ready: takes on 16 consecutive cycles,
        // words 0x00..0x0F back to back two cycles later.
        for (int i = 0; i < 20; i++)
            set_vec(i, 1'b1, (i < 16), (i >= 2 && i < 18), DW'(i - 2));
        run_table("stream", 20, 16);
`ifdef FIFO_READER_COUNT_EN
        check("stream.count", 32'(out_count), 32'd17);
`endif

        // Sixteen words, stalled for 10 cycles: exactly two takes, head
        // holds 0x00, 14 words remain in the FIFO.
        for (int i = 0; i < 10; i++)
            set_vec(i, 1'b0, (i < 2), (i >= 2), 8'h00);
        run_table("stall", 10, 16);
        check("stall.fifo_left", 32'(fifo_q.size()), 32'd14);
        // Release: taking resumes in the same cycle, 0x00..0x0F in order.
        for (int i = 0; i < 17; i++)
            set_vec(i, 1'b1, (i < 14), (i < 16), DW'(i));
        run_table("release", 17, 0);

        // Alternating ready with a 0x55 write every cycle.
        for (int c = 0; c < 200; c++) begin
            @(posedge in_clock); #1;
            in_ready = c[0];
            put_req  = 1'b1;
            put_word = 8'h55;
        end
        drain("alt");

        // Random ready and writes.
        for (int c = 0; c < 1500; c++) begin
            @(posedge in_clock); #1;
            in_ready = ($urandom_range(0, 3) != 0);
            put_req  = $urandom_range(0, 1) != 0;
            put_word = ($urandom_range(0, 3) == 0) ? 8'h55 : DW'($urandom);
        end
        drain("rand");

        // Reset with a word buffered and another in flight.
        @(posedge in_clock); #1;
        in_ready  = 1'b0;
        load_n    = 3;
        load_base = 8'h31;
        @(posedge in_clock); #1;
        load_n = 0;
        @(posedge in_clock); #1;
        @(posedge in_clock); #1;
        in_reset = 1'b1;
        in_ready = 1'b1;
        @(negedge in_clock);
        check("midrst.valid_before", 32'(out_valid), 32'd1);
        check("midrst.data_before", 32'(out_data), 32'h31);
        check("midrst.take_forced", 32'(out_fifo_take), 32'd0);
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        @(negedge in_clock);
        check("midrst.valid_after", 32'(out_valid), 32'd0);
`ifdef FIFO_READER_COUNT_EN
        check("midrst.count_after", 32'(out_count), 32'd0);
`endif
        for (int c = 0; c < 5; c++) begin
            @(posedge in_clock); #1;
            @(negedge in_clock);
            check("midrst.no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge in_clock); #1;
        put_req  = 1'b1;
        put_word = 8'hC3;
        @(posedge in_clock); #1;
        put_req = 1'b0;
        drain("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

endmodule : tb_fifo_reader
